// File: rtl/btn_event_pkg.sv
// Shared definitions for the push-button event front end: per-channel FSM
// state encoding and helpers that size the debounce and hold counters.
package btn_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    // Bits needed to hold the values 0..max_count (never less than one bit).
    function automatic int cnt_width(input int max_count);
        int w;
        if (max_count < 1) begin
            w = 1;
        end else begin
            w = $clog2(max_count + 1);
        end
        return w;
    endfunction

    // Larger of two integers; sizes the shared hold/repeat counter.
    function automatic int max_of(input int a, input int b);
        int m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

endpackage

// File: rtl/btn_event_ctrl_ch.sv
// Single button channel: pin synchroniser, debounce counter and the
// press / long-press / auto-repeat FSM. All event outputs are registered.
module btn_event_ch
    import btn_event_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 270000,
    parameter int LONG_CYCLES   = 27000000,
    parameter int REPEAT_CYCLES = 5400000,
    parameter int REPEAT_EN     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DEB_W  = cnt_width(DEB_CYCLES);
    localparam int HOLD_W = cnt_width(max_of(LONG_CYCLES, REPEAT_CYCLES));

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    // Pin level when the button is not pressed.
    localparam logic PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic REP_ON   = (REPEAT_EN != 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   raw_s;
    logic [DEB_W-1:0]       deb_cnt_r;
    logic [DEB_W-1:0]       deb_cnt_s;
    logic                   level_r;
    logic                   level_s;
    logic                   rise_s;
    logic                   fall_s;
    btn_state_e             state_r;
    btn_state_e             state_s;
    logic [HOLD_W-1:0]      hold_r;
    logic [HOLD_W-1:0]      hold_s;
    logic                   press_r;
    logic                   press_s;
    logic                   release_r;
    logic                   release_s;
    logic                   long_r;
    logic                   long_s;
    logic                   repeat_r;
    logic                   repeat_s;

    // Synchroniser chain; resets to the idle pin level so no event follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{PIN_IDLE}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
        end
    end

    // Raw "pressed" bit after polarity correction.
    assign raw_s = sync_r[SYNC_STAGES-1] ^ PIN_IDLE;

    // Debounce: accept a new level after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_cnt_s = {DEB_W{1'b0}};
        level_s   = level_r;
        if (raw_s != level_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                level_s   = ~level_r;
                deb_cnt_s = {DEB_W{1'b0}};
            end else begin
                deb_cnt_s = deb_cnt_r + DEB_ONE;
            end
        end else begin
            deb_cnt_s = {DEB_W{1'b0}};
        end
    end

    assign rise_s = level_s & ~level_r;
    assign fall_s = ~level_s & level_r;

    // Debounce counter and accepted level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_r <= {DEB_W{1'b0}};
            level_r   <= 1'b0;
        end else begin
            deb_cnt_r <= deb_cnt_s;
            level_r   <= level_s;
        end
    end

    // Event FSM next state; a release acceptance overrides any terminal count.
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        long_s    = 1'b0;
        repeat_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hold_s = {HOLD_W{1'b0}};
                if (rise_s) begin
                    press_s = 1'b1;
                    state_s = ST_HELD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (fall_s) begin
                    release_s = 1'b1;
                    hold_s    = {HOLD_W{1'b0}};
                    state_s   = ST_IDLE;
                end else if (hold_r == LONG_LAST) begin
                    long_s  = 1'b1;
                    hold_s  = {HOLD_W{1'b0}};
                    state_s = ST_REPEAT;
                end else begin
                    hold_s = hold_r + HOLD_ONE;
                end
            end
            ST_REPEAT: begin
                if (fall_s) begin
                    release_s = 1'b1;
                    hold_s    = {HOLD_W{1'b0}};
                    state_s   = ST_IDLE;
                end else if (REP_ON) begin
                    if (hold_r == REP_LAST) begin
                        repeat_s = 1'b1;
                        hold_s   = {HOLD_W{1'b0}};
                    end else begin
                        hold_s = hold_r + HOLD_ONE;
                    end
                end else begin
                    hold_s = {HOLD_W{1'b0}};
                end
            end
            default: begin
                hold_s  = {HOLD_W{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, hold counter and registered single-cycle event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            hold_r    <= {HOLD_W{1'b0}};
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            hold_r    <= hold_s;
            press_r   <= press_s;
            release_r <= release_s;
            long_r    <= long_s;
            repeat_r  <= repeat_s;
        end
    end

    assign level         = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;
    assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-channel push-button front end: NUM_BTN independent channels, each
// turning a raw asynchronous pin into a clean level plus single-cycle events.
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 270000,
    parameter int LONG_CYCLES   = 27000000,
    parameter int REPEAT_CYCLES = 5400000,
    parameter int REPEAT_EN     = 1
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic [NUM_BTN-1:0] iExtBtn,
    output logic [NUM_BTN-1:0] oLevel,
    output logic [NUM_BTN-1:0] oPress,
    output logic [NUM_BTN-1:0] oRelease,
    output logic [NUM_BTN-1:0] oLong,
    output logic [NUM_BTN-1:0] oRepeat
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_event_ch #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .SYNC_STAGES   (SYNC_STAGES),
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN)
        ) u_ch (
            .clk           (CLK),
            .rst_n         (RESETn),
            .pin           (iExtBtn[g]),
            .level         (oLevel[g]),
            .press_pulse   (oPress[g]),
            .release_pulse (oRelease[g]),
            .long_pulse    (oLong[g]),
            .repeat_pulse  (oRepeat[g])
        );
    end

endmodule
